// File: rtl/hamming_uart_rx_pkg.sv
// Shared Hamming(7,4) definitions and receiver FSM state encoding.
package hamming_uart_rx_pkg;

  localparam int CW_W  = 7;
  localparam int D_W   = 4;
  localparam int SYN_W = 3;

  // Codeword bit positions: parity at powers of two, data elsewhere.
  localparam int P1_POS = 0;
  localparam int P2_POS = 1;
  localparam int D0_POS = 2;
  localparam int P4_POS = 3;
  localparam int D1_POS = 4;
  localparam int D2_POS = 5;
  localparam int D3_POS = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_OUT,
    ST_BREAK
  } rx_state_e;

endpackage

// File: rtl/hamming74_dec.sv
// Combinational Hamming(7,4) single-error-correcting decoder.
module hamming74_dec
  import hamming_uart_rx_pkg::*;
(
  input  logic [CW_W-1:0]  cw,
  output logic [D_W-1:0]   d,
  output logic [SYN_W-1:0] syn,
  output logic             corrected
);

  logic [CW_W-1:0] fixed;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    fixed  = cw;
    // A non-zero syndrome names the 1-based position of the bad bit.
    if (syn != '0) fixed[syn - 3'd1] = ~fixed[syn - 3'd1];
    corrected = |syn;
    d = {fixed[D3_POS], fixed[D2_POS], fixed[D1_POS], fixed[D0_POS]};
  end

endmodule

// File: rtl/hamming_uart_rx.sv
// UART-style receiver for 7-bit Hamming codewords: synchronise, deserialise,
// correct a single-bit error and count corrections.
module hamming_uart_rx
  import hamming_uart_rx_pkg::*;
#(
  parameter int BIT_TICKS = 104,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  output logic [D_W-1:0]   d_out,
  output logic             d_valid,
  output logic             corrected,
  output logic [SYN_W-1:0] syndrome,
  output logic             frame_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int TICK_W = $clog2(BIT_TICKS);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(BIT_TICKS / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(BIT_TICKS - 1);

  rx_state_e       state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic [CW_W-1:0] shift_q, shift_d;
  logic            rx_meta_q, rx_s_q;
  logic            load, frame_bad;

  logic [D_W-1:0]   dec_d;
  logic [SYN_W-1:0] dec_syn;
  logic             dec_corr;

  hamming74_dec u_dec (
    .cw        (shift_q),
    .d         (dec_d),
    .syn       (dec_syn),
    .corrected (dec_corr)
  );

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    load      = 1'b0;
    frame_bad = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        if (!rx_s_q) state_d = ST_START;
      end
      ST_START: if (tick_q == HALF_LAST) begin
        tick_d  = '0;
        bit_d   = '0;
        state_d = rx_s_q ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (tick_q == FULL_LAST) begin
        tick_d         = '0;
        shift_d[bit_q] = rx_s_q;
        bit_d          = bit_q + 3'd1;
        if (bit_q == 3'(CW_W - 1)) state_d = ST_STOP;
      end
      ST_STOP: if (tick_q == FULL_LAST) begin
        tick_d = '0;
        if (rx_s_q) begin
          load    = 1'b1;
          state_d = ST_OUT;
        end else begin
          frame_bad = 1'b1;
          state_d   = ST_BREAK;
        end
      end
      ST_OUT: begin
        tick_d  = '0;
        state_d = ST_IDLE;
      end
      ST_BREAK: begin
        // Hold off until the line returns high so a stuck-low line cannot re-arm START.
        tick_d = '0;
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      d_out     <= '0;
      syndrome  <= '0;
      d_valid   <= 1'b0;
      corrected <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      d_valid   <= load;
      corrected <= load & dec_corr;
      frame_err <= frame_bad;
      if (load) begin
        d_out    <= dec_d;
        syndrome <= dec_syn;
        if (dec_corr && err_count != '1) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hamming_uart_rx.sv
// Scoreboard bench for hamming_uart_rx: frames are encoded by the bench,
// expected decodes queued on send and checked when d_valid pulses.
`timescale 1ns/1ps
module tb_hamming_uart_rx;

  localparam int BIT_TICKS = 8;
  localparam int CNT_W     = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rx  = 1'b1;
  logic [3:0]       d_out;
  logic             d_valid;
  logic             corrected;
  logic [2:0]       syndrome;
  logic             frame_err;
  logic [CNT_W-1:0] err_count;

  typedef struct packed {
    logic [3:0]       d;
    logic [2:0]       syn;
    logic             corr;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  exp_t             obs;
  exp_t             exp_e;
  int               checks = 0;
  int               errors = 0;
  int               fe_seen = 0;
  logic [CNT_W-1:0] cnt_exp = '0;

  hamming_uart_rx #(.BIT_TICKS(BIT_TICKS), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .d_out     (d_out),
    .d_valid   (d_valid),
    .corrected (corrected),
    .syndrome  (syndrome),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  always #50 clk = ~clk;

  function automatic logic [6:0] encode(input logic [3:0] d);
    encode = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0],
              d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (d_valid) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_d_valid d_out=%h syndrome=%0d", d_out, syndrome);
          end else begin
            exp_e = sb.pop_front();
            obs   = {d_out, syndrome, corrected, err_count};
            if (obs !== exp_e) begin
              errors++;
              $display("FAIL decode got d=%h syn=%0d corr=%b cnt=%0d want d=%h syn=%0d corr=%b cnt=%0d",
                       d_out, syndrome, corrected, err_count,
                       exp_e.d, exp_e.syn, exp_e.corr, exp_e.cnt);
            end
          end
        end else begin
          checks++;
          if (corrected !== 1'b0) begin
            errors++;
            $display("FAIL corrected_idle got %b want 0", corrected);
          end
        end
        if (frame_err) fe_seen++;
      end
    end
  endtask

  task automatic drive_bits(input logic v, input int n_bits);
    rx = v;
    repeat (n_bits * BIT_TICKS) @(negedge clk);
  endtask

  task automatic send_cw(input logic [6:0] cw, input logic stop_v);
    drive_bits(1'b0, 1);
    for (int i = 0; i < 7; i++) drive_bits(cw[i], 1);
    drive_bits(stop_v, 1);
    rx = 1'b1;
  endtask

  // Queue the expected decode, then transmit and leave idle time for the output.
  task automatic send_expect(input logic [6:0] cw, input logic [3:0] d, input logic [2:0] syn);
    exp_t e;
    if (syn != 3'd0 && cnt_exp != '1) cnt_exp = cnt_exp + 1'b1;
    e = {d, syn, (syn != 3'd0), cnt_exp};
    sb.push_back(e);
    send_cw(cw, 1'b1);
    drive_bits(1'b1, 2);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s pending_outputs got %0d want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if ({d_out, syndrome, corrected, d_valid, frame_err, err_count} !== '0) begin
      errors++;
      $display("FAIL %s d=%h syn=%0d corr=%b dv=%b fe=%b cnt=%0d want all 0",
               name, d_out, syndrome, corrected, d_valid, frame_err, err_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset_state");
    rst = 1'b0;
    drive_bits(1'b1, 2);
  endtask

  task automatic test_clean();
    send_expect(7'h55, 4'hB, 3'd0);
    check_drained("clean_frame");
  endtask

  task automatic test_single();
    send_expect(7'h45, 4'hB, 3'd5);
    check_drained("single_flip_c4");
  endtask

  task automatic test_sweep();
    for (int d = 0; d < 16; d++)
      for (int j = 0; j < 7; j++)
        send_expect(encode(4'(d)) ^ (7'd1 << j), 4'(d), 3'(j + 1));
    check_drained("sweep");
    checks++;
    if (err_count !== '1) begin
      errors++;
      $display("FAIL err_count_saturate got %0d want %0d", err_count, {CNT_W{1'b1}});
    end
  endtask

  task automatic test_frame_err();
    int fe0 = fe_seen;
    logic [6:0] cw = encode(4'h6);
    drive_bits(1'b0, 1);
    for (int i = 0; i < 7; i++) drive_bits(cw[i], 1);
    drive_bits(1'b0, 4);
    drive_bits(1'b1, 3);
    checks++;
    if (fe_seen != fe0 + 1) begin
      errors++;
      $display("FAIL frame_err_pulses got %0d want 1", fe_seen - fe0);
    end
    check_drained("frame_err_no_output");
    send_expect(encode(4'h9), 4'h9, 3'd0);
    check_drained("after_break");
  endtask

  task automatic test_glitch();
    int fe0 = fe_seen;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    drive_bits(1'b1, 12);
    checks++;
    if (fe_seen != fe0) begin
      errors++;
      $display("FAIL glitch_frame_err got %0d want 0", fe_seen - fe0);
    end
    check_drained("glitch_no_output");
    send_expect(encode(4'hC) ^ 7'h02, 4'hC, 3'd2);
    check_drained("after_glitch");
  endtask

  task automatic test_reset_mid();
    logic [6:0] cw = encode(4'h5);
    drive_bits(1'b0, 1);
    for (int i = 0; i < 3; i++) drive_bits(cw[i], 1);
    rx = cw[3];
    repeat (BIT_TICKS / 2) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    check_zero_outputs("reset_mid_frame");
    rst     = 1'b0;
    cnt_exp = '0;
    drive_bits(1'b1, 12);
    check_drained("reset_no_output");
    send_expect(encode(4'h3) ^ 7'h04, 4'h3, 3'd3);
    check_drained("after_reset");
  endtask

  initial begin
    fork
      monitor_loop();
    join_none
    test_reset();
    test_clean();
    test_single();
    test_sweep();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
